// File: rtl/dc_mem_pkg.sv
// Shared types and constants for the D-cache memory-side responder.
// Tile constants are common to the cache and its backing memory.
package dc_mem_pkg;

  localparam int DWORD_W     = 32;
  localparam int TILE_DWORDS = 4;
  localparam int TILE_SHIFT  = 4;

  localparam logic KIND_RD = 1'b0;
  localparam logic KIND_WR = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/dc_mem_array.sv
// Single-port synchronous word RAM, read-before-write, 1-cycle read.
// Contents are deliberately not reset.
module dc_mem_array
  import dc_mem_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic               clock,
  input  logic               we,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [DWORD_W-1:0] wdata,
  output logic [DWORD_W-1:0] rdata
);

  logic [DWORD_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (we) r_mem[addr] <= wdata;
    rdata <= r_mem[addr];
  end

endmodule

// File: rtl/dc_mem_responder.sv
// D-cache fill/writeback responder: latches one DWORD request,
// waits LATENCY cycles, then answers with a one-cycle OK strobe.
module dc_mem_responder
  import dc_mem_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [31:0]        memPcAddr,
  input  logic               memPcOE,
  input  logic               memPcWR,
  input  logic [DWORD_W-1:0] memOutData,
  output logic [DWORD_W-1:0] memPcData,
  output logic               memPcOK
);

  localparam logic [3:0] LAT = 4'(LATENCY);

  state_t               r_state, w_next;
  logic [3:0]           r_cnt, w_cnt;
  logic [ADDR_W-1:0]    r_addr;
  logic [DWORD_W-1:0]   r_wdata;
  logic                 r_kind;
  logic                 r_ok;
  logic [DWORD_W-1:0]   r_data;
  logic [DWORD_W-1:0]   w_rdata;
  logic                 w_req, w_lvl;
  logic                 w_latch, w_fire, w_we;
  logic                 w_unused;

  assign w_unused = ^{memPcAddr[31:ADDR_W+2], memPcAddr[1:0]};

  assign w_req = memPcWR | memPcOE;
  assign w_lvl = (r_kind == KIND_WR) ? memPcWR : memPcOE;

  always_comb begin
    w_next  = r_state;
    w_cnt   = r_cnt;
    w_latch = 1'b0;
    w_fire  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_req) begin
          w_latch = 1'b1;
          w_cnt   = LAT;
          w_next  = WAIT;
        end
      end
      WAIT: begin
        if (!w_lvl) begin
          w_next = IDLE;
        end else if (r_cnt == 4'd0) begin
          w_fire = 1'b1;
          w_next = RESP;
        end else begin
          w_cnt = r_cnt - 4'd1;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // A reset landing on the commit edge must still discard the write
  assign w_we = w_fire & (r_kind == KIND_WR) & ~reset;

  dc_mem_array #(
    .ADDR_W(ADDR_W)
  ) u_array (
    .clock(clock),
    .we   (w_we),
    .addr (r_addr),
    .wdata(r_wdata),
    .rdata(w_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_kind  <= KIND_RD;
      r_ok    <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      if (w_latch) begin
        r_addr  <= memPcAddr[ADDR_W+1:2];
        r_wdata <= memOutData;
        r_kind  <= memPcWR ? KIND_WR : KIND_RD;
      end
      r_ok   <= (r_state == RESP);
      r_data <= (r_state == RESP && r_kind == KIND_RD) ? w_rdata : '0;
    end
  end

  assign memPcOK   = r_ok;
  assign memPcData = r_data;

endmodule

// File: tb/tb_dc_mem_responder.sv
// Randomized + directed bench for dc_mem_responder (LATENCY 2 and 0),
// checked every cycle against a timestamp-based reference model.
module tb_dc_mem_responder;

  localparam int AW = 12;

  function automatic int latof(input int u);
    return (u == 0) ? 2 : 0;
  endfunction

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr [2];
  logic [31:0] wd   [2];
  logic        oe   [2];
  logic        wr   [2];
  logic        ok   [2];
  logic [31:0] data [2];

  always #5 clk = ~clk;

  dc_mem_responder #(.ADDR_W(AW), .LATENCY(2)) u_dut2 (
    .clock(clk), .reset(rst),
    .memPcAddr(addr[0]), .memPcOE(oe[0]), .memPcWR(wr[0]),
    .memOutData(wd[0]), .memPcData(data[0]), .memPcOK(ok[0])
  );

  dc_mem_responder #(.ADDR_W(AW), .LATENCY(0)) u_dut0 (
    .clock(clk), .reset(rst),
    .memPcAddr(addr[1]), .memPcOE(oe[1]), .memPcWR(wr[1]),
    .memOutData(wd[1]), .memPcData(data[1]), .memPcOK(ok[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: each accepted request is a timestamp k; it commits
  // at k+1+L and strobes OK after edge k+2+L unless its line drops first.
  int          cyc = 0;
  bit          chk_en = 0;
  bit          busy [2];
  int          mk   [2];
  logic        kind [2];
  logic [AW-1:0] ma [2];
  logic [31:0] md   [2];
  logic [31:0] rv   [2];
  bit          rk   [2];
  logic [31:0] mm   [int];
  logic        e_ok [2];
  logic [31:0] e_data [2];
  bit          e_dk [2];

  initial begin
    for (int u = 0; u < 2; u++) busy[u] = 0;
    forever begin
      @(posedge clk);
      cyc++;
      for (int u = 0; u < 2; u++) begin
        logic lvl;
        int   key;
        e_ok[u]   = 1'b0;
        e_data[u] = '0;
        e_dk[u]   = 1'b1;
        if (rst) begin
          busy[u] = 0;
          chk_en  = 1;
        end else if (busy[u]) begin
          lvl = kind[u] ? wr[u] : oe[u];
          key = u * 4096 + int'(ma[u]);
          if (cyc == mk[u] + 2 + latof(u)) begin
            e_ok[u]   = 1'b1;
            e_data[u] = kind[u] ? 32'h0 : rv[u];
            e_dk[u]   = kind[u] | rk[u];
            busy[u]   = 0;
          end else if (!lvl) begin
            busy[u] = 0;
          end else if (cyc == mk[u] + 1 + latof(u)) begin
            rk[u] = mm.exists(key);
            rv[u] = rk[u] ? mm[key] : 32'h0;
            if (kind[u]) mm[key] = md[u];
          end
        end else if (wr[u] || oe[u]) begin
          busy[u] = 1;
          mk[u]   = cyc;
          kind[u] = wr[u];
          ma[u]   = addr[u][AW+1:2];
          md[u]   = wd[u];
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int u = 0; u < 2; u++) begin
          check($sformatf("ok[u%0d]", u), {31'b0, ok[u]}, {31'b0, e_ok[u]});
          if (e_dk[u])
            check($sformatf("data[u%0d]", u), data[u], e_data[u]);
        end
      end
    end
  end

  task automatic xfer(input int u, input logic w, input logic o,
                      input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output int dt);
    int k;
    bit got;
    addr[u] = a; wd[u] = d; wr[u] = w; oe[u] = o;
    k = cyc + 1; got = 0; dt = -1; rd = 'x;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      if (ok[u]) begin
        got = 1; dt = cyc - k; rd = data[u];
      end
    end
    wr[u] = 1'b0; oe[u] = 1'b0;
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL xfer_timeout u%0d: got no OK want OK", u);
    end
    @(posedge clk); #1;
  endtask

  task automatic stream(input int u, input logic [31:0] base, input int n,
                        input logic [31:0] exp [8], input string nm);
    int k, last;
    bit got;
    addr[u] = base; oe[u] = 1'b1; wr[u] = 1'b0;
    k = cyc + 1; last = 0;
    for (int i = 0; i < n; i++) begin
      got = 0;
      for (int j = 0; j < 40 && !got; j++) begin
        @(posedge clk); #1;
        if (ok[u]) got = 1;
      end
      if (!got) begin
        n_cmp++; n_bad++;
        $display("FAIL %s_timeout beat %0d: got no OK want OK", nm, i);
        break;
      end
      check($sformatf("%s_data%0d", nm, i), data[u], exp[i]);
      if (i == 0) check({nm, "_first"}, cyc - k, 2 + latof(u));
      else check($sformatf("%s_gap%0d", nm, i), cyc - last, 3 + latof(u));
      last = cyc;
      addr[u] = addr[u] + 32'd4;
      if (i == n - 1) oe[u] = 1'b0;
    end
    oe[u] = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] ex [8];
    int dt, k, n;
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      addr[u] = 32'h104; wd[u] = '0; wr[u] = 1'b0; oe[u] = 1'b0;
    end
    oe[0] = 1'b1;

    // Reset held 3 cycles with OE high, then first OK after 2+L
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    k = cyc + 1; n = -1;
    for (int i = 0; i < 20 && n < 0; i++) begin
      @(posedge clk); #1;
      if (ok[0]) n = cyc - k;
    end
    oe[0] = 1'b0;
    check("reset_first_ok", n, 4);
    @(posedge clk); #1;

    // Write then read back at LATENCY=2
    xfer(0, 1'b1, 1'b0, 32'h0000_0104, 32'hDEADBEEF, rd, dt);
    check("wr_data", rd, 32'h0);
    check("wr_lat", dt, 4);
    xfer(0, 1'b0, 1'b1, 32'h0000_0104, 32'h0, rd, dt);
    check("rd_data", rd, 32'hDEADBEEF);
    check("rd_lat", dt, 4);

    // Tile fill
    for (int i = 0; i < 4; i++)
      xfer(0, 1'b1, 1'b0, 32'h40 + 32'(4 * i), 32'(17 * (i + 1)), rd, dt);
    ex = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h0, 32'h0, 32'h0, 32'h0};
    stream(0, 32'h40, 4, ex, "tile");

    // OE dropped while cnt==1: no response
    addr[0] = 32'h104; oe[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    oe[0] = 1'b0;
    n = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (ok[0]) n++;
    end
    check("abort_no_ok", n, 0);

    // Reset before the commit edge discards the write
    addr[0] = 32'h104; wd[0] = 32'h12345678; wr[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; wr[0] = 1'b0;
    @(posedge clk); #1;
    xfer(0, 1'b0, 1'b1, 32'h104, 32'h0, rd, dt);
    check("rst_discard", rd, 32'hDEADBEEF);

    // WR beats OE; bit 14 wraps to word 0
    xfer(0, 1'b1, 1'b1, 32'h0000_4000, 32'h5A5A5A5A, rd, dt);
    check("prio_data", rd, 32'h0);
    xfer(0, 1'b0, 1'b1, 32'h0000_0000, 32'h0, rd, dt);
    check("wrap_rd", rd, 32'h5A5A5A5A);

    // LATENCY=0: 8 back-to-back reads
    for (int i = 0; i < 8; i++) begin
      ex[i] = $urandom;
      xfer(1, 1'b1, 1'b0, 32'h200 + 32'(4 * i), ex[i], rd, dt);
    end
    check("l0_wr_lat", dt, 2);
    stream(1, 32'h200, 8, ex, "b2b");

    // Random traffic on both instances, including aborts
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 8; i++)
        xfer(u, 1'b1, 1'b0, 32'h300 + 32'(4 * i), $urandom, rd, dt);
      for (int i = 0; i < 40; i++) begin
        logic [31:0] a;
        logic w, o;
        a = (32'($urandom_range(0, 15)) << 14) | 32'h300 |
            (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
        w = 1'($urandom_range(0, 1));
        o = ~w | 1'($urandom_range(0, 1));
        if ($urandom_range(0, 4) == 0) begin
          addr[u] = a; wd[u] = $urandom; wr[u] = w; oe[u] = o;
          repeat ($urandom_range(1, latof(u) + 3)) @(posedge clk);
          #1;
          wr[u] = 1'b0; oe[u] = 1'b0;
          repeat (6) @(posedge clk);
          #1;
        end else begin
          xfer(u, w, o, a, $urandom, rd, dt);
        end
      end
    end

    repeat (4) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
